// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, select codes, opcodes and decode helpers for the multi-cycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_BRANCH   = 4'd4,
        S_JUMP     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_TRAP     = 4'd11
    } st_t;

    localparam logic [1:0] B_RT = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_SHIMM = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_mode;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
    } ctl_t;

    function automatic st_t decode_op(logic [5:0] op);
        case (op)
            OP_RTYPE:                                               return S_EXEC_R;
            OP_LW, OP_SW:                                           return S_MEM_ADDR;
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: return S_EXEC_I;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:            return S_BRANCH;
            OP_J:                                                   return S_JUMP;
            default:                                                return S_TRAP;
        endcase
    endfunction

    // rt marks an R-type instruction: selects rd in WB_ALU and the JR path in JUMP
    function automatic ctl_t moore(st_t s, logic rt);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = B_FOUR; end
            S_DECODE:   c.alu_src_b = B_SHIMM;
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = B_RT; c.alu_mode = 1'b1; end
            S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = B_IMM; c.alu_mode = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_src_b = B_RT; c.alu_mode = 1'b1; c.pc_src = PC_ALUOUT; end
            S_JUMP:     begin c.pc_we = 1'b1; c.pc_src = rt ? PC_ALU : PC_JUMP; c.alu_src_a = rt; end
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = B_IMM; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = 1'b1; end
            S_WB_ALU:   begin c.reg_we = 1'b1; c.reg_dst = rt; end
            S_WB_MEM:   begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            S_TRAP:     c.trap = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_timeout.sv
// mc_timeout: memory wait counter that flags the last allowed wait cycle
module mc_timeout #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = r_cnt == TO_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM sequencing fetch, decode, execute, memory and writeback
import mc_ctrl_pkg::*;

module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ack,
    input  logic       i_br_cond,
    output logic       o_pc_we,
    output logic [1:0] o_pc_src,
    output logic       o_ir_we,
    output logic       o_iord,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_alu_mode,
    output logic       o_reg_we,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_trap,
    output logic [3:0] o_state
);
    st_t  r_state, w_next;
    ctl_t r_ctl;
    logic r_rtype, w_rtype;
    logic w_ack, w_exp, w_to, w_clr;

    // ack only counts while a request is actually on the bus
    assign w_ack = i_mem_ack & r_ctl.mem_req;
    assign w_to  = r_ctl.mem_req & ~i_mem_ack & w_exp;
    assign w_clr = ~r_ctl.mem_req | i_mem_ack;

    mc_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_en      (r_ctl.mem_req),
        .o_expired (w_exp)
    );

    always_comb begin
        w_next  = r_state;
        w_rtype = r_rtype;
        case (r_state)
            S_FETCH:    w_next = w_ack ? S_DECODE : w_to ? S_TRAP : S_FETCH;
            S_DECODE:   begin w_next = decode_op(i_opcode); w_rtype = i_opcode == OP_RTYPE; end
            S_EXEC_R:   w_next = i_funct == FN_JR ? S_JUMP : S_WB_ALU;
            S_EXEC_I:   w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = i_opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = w_ack ? S_WB_MEM : w_to ? S_TRAP : S_MEM_RD;
            S_MEM_WR:   w_next = w_ack ? S_FETCH : w_to ? S_TRAP : S_MEM_WR;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // outputs are registered from the next state so reset holds them all at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_rtype <= 1'b0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_rtype <= w_rtype;
            r_ctl   <= moore(w_next, w_rtype);
        end
    end

    assign o_ir_we      = (r_state == S_FETCH) & w_ack;
    assign o_pc_we      = r_ctl.pc_we | o_ir_we | ((r_state == S_BRANCH) & i_br_cond);
    assign o_pc_src     = r_ctl.pc_src;
    assign o_iord       = r_ctl.iord;
    assign o_mem_req    = r_ctl.mem_req;
    assign o_mem_we     = r_ctl.mem_we;
    assign o_alu_src_a  = r_ctl.alu_src_a;
    assign o_alu_src_b  = r_ctl.alu_src_b;
    assign o_alu_mode   = r_ctl.alu_mode;
    assign o_reg_we     = r_ctl.reg_we;
    assign o_reg_dst    = r_ctl.reg_dst;
    assign o_mem_to_reg = r_ctl.mem_to_reg;
    assign o_trap       = r_ctl.trap;
    assign o_state      = r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven, hand-written and randomized checks of mc_ctrl against an instruction-level model
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       mem_ack = 1'b0, br_cond = 1'b0;
    logic       o_pc_we, o_ir_we, o_iord, o_mem_req, o_mem_we, o_alu_src_a, o_alu_mode;
    logic       o_reg_we, o_reg_dst, o_mem_to_reg, o_trap;
    logic [1:0] o_pc_src, o_alu_src_b;
    logic [3:0] o_state;

    mc_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_mem_ack    (mem_ack),
        .i_br_cond    (br_cond),
        .o_pc_we      (o_pc_we),
        .o_pc_src     (o_pc_src),
        .o_ir_we      (o_ir_we),
        .o_iord       (o_iord),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_mode   (o_alu_mode),
        .o_reg_we     (o_reg_we),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_trap       (o_trap),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, ncyc = 0;
    bit noise = 1'b0;

    logic [18:0] obs;
    assign obs = {o_state, o_pc_we, o_pc_src, o_ir_we, o_iord, o_mem_req, o_mem_we,
                  o_alu_src_a, o_alu_src_b, o_alu_mode, o_reg_we, o_reg_dst, o_mem_to_reg, o_trap};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // expected outputs per phase, straight from the control table
    function automatic logic [18:0] exp_out(st_t s, bit ack, bit br, bit jr, bit rdst);
        logic pc_we, ir_we, iord, req, we, a, mode, rwe, rd, m2r, tr;
        logic [1:0] psrc, b;
        {pc_we, ir_we, iord, req, we, a, mode, rwe, rd, m2r, tr} = '0;
        psrc = 2'd0;
        b = 2'd0;
        case (s)
            S_FETCH:    begin req = 1; b = 2'd1; ir_we = ack; pc_we = ack; end
            S_DECODE:   b = 2'd3;
            S_EXEC_R:   begin a = 1; mode = 1; end
            S_EXEC_I:   begin a = 1; b = 2'd2; mode = 1; end
            S_BRANCH:   begin a = 1; mode = 1; psrc = 2'd1; pc_we = br; end
            S_JUMP:     begin pc_we = 1; psrc = jr ? 2'd0 : 2'd2; a = jr; end
            S_MEM_ADDR: begin a = 1; b = 2'd2; end
            S_MEM_RD:   begin req = 1; iord = 1; end
            S_MEM_WR:   begin req = 1; iord = 1; we = 1; end
            S_WB_ALU:   begin rwe = 1; rd = rdst; end
            S_WB_MEM:   begin rwe = 1; m2r = 1; end
            default:    tr = 1;
        endcase
        return {s, pc_we, psrc, ir_we, iord, req, we, a, b, mode, rwe, rd, m2r, tr};
    endfunction

    function automatic bit nz();
        return noise ? 1'($urandom % 2) : 1'b0;
    endfunction

    // called at a falling edge; drives inputs, checks, advances one clock
    task automatic step(st_t s, bit ack, bit br = 0, bit jr = 0, bit rdst = 0, bit idle = 0);
        logic [18:0] e;
        mem_ack = ack;
        br_cond = br;
        #1;
        e = idle ? {S_FETCH, 15'b0} : exp_out(s, ack, br, jr, rdst);
        check(idle ? "idle" : s.name(), 32'(obs), 32'(e));
        ncyc++;
        @(negedge clk);
    endtask

    task automatic req_phase(st_t s, int wait_n, output bit to);
        bit ack;
        to = 0;
        for (int k = 1; k <= wait_n + 1; k++) begin
            ack = (k == wait_n + 1);
            step(s, ack);
            if (!ack && k == TO) begin
                to = 1;
                return;
            end
        end
    endtask

    task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit br, int fw, int mw,
                             output int cyc, output bit tr);
        int t0;
        bit to;
        t0 = ncyc;
        opcode = op;
        funct = fn;
        tr = 0;
        req_phase(S_FETCH, fw, to);
        if (to) tr = 1;
        else begin
            step(S_DECODE, nz());
            if (op == 6'h00 && fn == 6'h08) begin
                step(S_EXEC_R, nz());
                step(S_JUMP, nz(), 0, 1);
            end else if (op == 6'h00) begin
                step(S_EXEC_R, nz());
                step(S_WB_ALU, nz(), 0, 0, 1);
            end else if (op inside {[6'h09:6'h0F]}) begin
                step(S_EXEC_I, nz());
                step(S_WB_ALU, nz());
            end else if (op inside {6'h01, [6'h04:6'h07]}) begin
                step(S_BRANCH, nz(), br);
            end else if (op == 6'h02) begin
                step(S_JUMP, nz());
            end else if (op == 6'h23) begin
                step(S_MEM_ADDR, nz());
                req_phase(S_MEM_RD, mw, to);
                if (to) tr = 1;
                else step(S_WB_MEM, nz());
            end else if (op == 6'h2B) begin
                step(S_MEM_ADDR, nz());
                req_phase(S_MEM_WR, mw, to);
                tr = to;
            end else tr = 1;
        end
        cyc = ncyc - t0;
        if (tr) step(S_TRAP, 1'b1);
    endtask

    // entered at a falling edge; pulls reset mid-cycle to expose asynchronous clearing
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(obs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(S_FETCH, 1'b1, 0, 0, 0, 1);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         br;
        int         fw;
        int         mw;
        int         cyc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cyc;
        bit tr;
        logic [5:0] ops[20];
        tbl[0]  = '{6'h00, 6'h21, 1'b0, 0, 0, 4};
        tbl[1]  = '{6'h0D, 6'h00, 1'b0, 0, 0, 4};
        tbl[2]  = '{6'h23, 6'h00, 1'b0, 0, 0, 5};
        tbl[3]  = '{6'h2B, 6'h00, 1'b0, 0, 0, 4};
        tbl[4]  = '{6'h04, 6'h00, 1'b0, 0, 0, 3};
        tbl[5]  = '{6'h04, 6'h00, 1'b1, 0, 0, 3};
        tbl[6]  = '{6'h02, 6'h00, 1'b0, 0, 0, 3};
        tbl[7]  = '{6'h00, 6'h08, 1'b0, 0, 0, 4};
        tbl[8]  = '{6'h00, 6'h21, 1'b0, 2, 0, 6};
        tbl[9]  = '{6'h23, 6'h00, 1'b0, 1, 2, 8};
        tbl[10] = '{6'h0F, 6'h00, 1'b0, 3, 0, 7};
        tbl[11] = '{6'h06, 6'h00, 1'b1, 0, 0, 3};
        ops = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h08, 6'h03};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].br, tbl[i].fw, tbl[i].mw, cyc, tr);
            check("cycles", 32'(cyc), 32'(tbl[i].cyc));
        end

        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, cyc, tr);
        for (int i = 0; i < 3; i++) step(S_TRAP, 1'b1);
        do_reset();

        run_instr(6'h00, 6'h21, 1'b0, TO, 0, cyc, tr);
        step(S_TRAP, 1'b0);
        do_reset();

        run_instr(6'h23, 6'h00, 1'b0, 0, TO + 1, cyc, tr);
        do_reset();

        opcode = 6'h23;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b0);
        step(S_MEM_ADDR, 1'b0);
        step(S_MEM_RD, 1'b0);
        do_reset();
        run_instr(6'h00, 6'h21, 1'b0, 0, 0, cyc, tr);
        check("after_abort", 32'(cyc), 32'd4);

        noise = 1'b1;
        for (int i = 0; i < 300; i++) begin
            run_instr(ops[$urandom_range(0, 19)],
                      ($urandom % 4 == 0) ? 6'h08 : 6'($urandom % 64),
                      1'($urandom % 2),
                      ($urandom % 6 == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                      ($urandom % 6 == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                      cyc, tr);
            if (tr) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
